// File: rtl/count_bcd_display.sv
// Binary (0..127) to 3-digit BCD via a sequential double-dabble engine, driving a
// multiplexed common-anode 7-segment display with leading-zero blanking.
module count_bcd_display #(
    parameter int unsigned REFRESH_DIV = 100000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [6:0]  value_in,
    input  logic        load,
    output logic        busy,
    output logic        bcd_valid,
    output logic [11:0] bcd,
    output logic [6:0]  seg,
    output logic [2:0]  an
);

    localparam int unsigned CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

    typedef enum logic {IDLE, CONV} state_t;

    state_t        r_state, w_state_next;
    logic [6:0]    r_shift;
    logic [11:0]   r_scratch;
    logic [2:0]    r_iter;
    logic [11:0]   r_bcd;
    logic          r_valid;
    logic [CW-1:0] r_ref_cnt;
    logic [1:0]    r_digit;

    logic [11:0]   w_adj;
    logic [11:0]   w_scratch_sh;
    logic [6:0]    w_shift_sh;
    logic          w_last;
    logic          w_wrap;
    logic [3:0]    w_nib;
    logic          w_blank;

    // Add-3 correction on every nibble >= 5, applied before the shift.
    always_comb begin
        w_adj = r_scratch;
        for (int unsigned i = 0; i < 3; i++) begin
            if (r_scratch[i*4 +: 4] >= 4'd5)
                w_adj[i*4 +: 4] = r_scratch[i*4 +: 4] + 4'd3;
        end
    end

    assign w_scratch_sh = {w_adj[10:0], r_shift[6]};
    assign w_shift_sh   = {r_shift[5:0], 1'b0};
    assign w_last       = (r_iter == 3'd6);

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (load) w_state_next = CONV;
            CONV:    if (w_last) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_shift   <= '0;
            r_scratch <= '0;
            r_iter    <= '0;
            r_bcd     <= '0;
            r_valid   <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (load) begin
                        r_shift   <= value_in;
                        r_scratch <= '0;
                        r_iter    <= '0;
                    end
                end
                CONV: begin
                    r_shift   <= w_shift_sh;
                    r_scratch <= w_scratch_sh;
                    r_iter    <= r_iter + 3'd1;
                    if (w_last) begin
                        r_bcd   <= w_scratch_sh;
                        r_valid <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy      = (r_state == CONV);
    assign bcd_valid = r_valid;
    assign bcd       = r_bcd;

    // Free-running refresh, independent of the conversion engine.
    assign w_wrap = (r_ref_cnt == CW'(REFRESH_DIV - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ref_cnt <= '0;
            r_digit   <= 2'd0;
        end else if (w_wrap) begin
            r_ref_cnt <= '0;
            r_digit   <= (r_digit == 2'd2) ? 2'd0 : r_digit + 2'd1;
        end else begin
            r_ref_cnt <= r_ref_cnt + CW'(1);
        end
    end

    always_comb begin
        w_nib   = r_bcd[3:0];
        w_blank = 1'b0;
        an      = 3'b110;
        case (r_digit)
            2'd1: begin
                w_nib   = r_bcd[7:4];
                w_blank = (r_bcd[11:8] == 4'd0) && (r_bcd[7:4] == 4'd0);
                an      = 3'b101;
            end
            2'd2: begin
                w_nib   = r_bcd[11:8];
                w_blank = (r_bcd[11:8] == 4'd0);
                an      = 3'b011;
            end
            default: ;
        endcase
    end

    always_comb begin
        seg = 7'b1111111;
        if (!w_blank) begin
            case (w_nib)
                4'd0:    seg = 7'b1000000;
                4'd1:    seg = 7'b1111001;
                4'd2:    seg = 7'b0100100;
                4'd3:    seg = 7'b0110000;
                4'd4:    seg = 7'b0011001;
                4'd5:    seg = 7'b0010010;
                4'd6:    seg = 7'b0000010;
                4'd7:    seg = 7'b1111000;
                4'd8:    seg = 7'b0000000;
                4'd9:    seg = 7'b0010000;
                default: seg = 7'b1111111;
            endcase
        end
    end

endmodule

// File: tb/tb_count_bcd_display.sv
// Scoreboard bench for count_bcd_display: conversion results, timing, load drop,
// reset abort and the multiplexed display with blanking.
module tb_count_bcd_display;

    logic        clk;
    logic        rst;
    logic [6:0]  value_in;
    logic        load;
    logic        busy;
    logic        bcd_valid;
    logic [11:0] bcd;
    logic [6:0]  seg;
    logic [2:0]  an;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [11:0] bcd;
        int          cyc;
    } exp_t;

    exp_t        q[$];
    int          cyc    = 0;
    int          m_cnt  = 0;
    logic [11:0] m_bcd  = '0;
    bit          chk_en = 0;

    count_bcd_display #(.REFRESH_DIV(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .value_in  (value_in),
        .load      (load),
        .busy      (busy),
        .bcd_valid (bcd_valid),
        .bcd       (bcd),
        .seg       (seg),
        .an        (an)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h expected %0h at cycle %0d", tag, obs, exp, cyc);
        end
    endtask

    function automatic logic [11:0] to_bcd(input int v);
        logic [3:0] h, t, u;
        h = 4'(v / 100);
        t = 4'((v / 10) % 10);
        u = 4'(v % 10);
        return {h, t, u};
    endfunction

    function automatic logic [6:0] seg_of(input int d);
        case (d)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            9: return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    // Monitor: compare against queued expectations, then advance the model.
    initial begin
        bit exp_v;
        forever begin
            @(negedge clk);
            cyc = cyc + 1;
            if (chk_en) begin
                exp_v = (q.size() > 0) && (q[0].cyc + 8 == cyc);
                check("busy", busy, m_cnt > 0);
                check("bcd_valid", bcd_valid, exp_v);
                if (exp_v) begin
                    m_bcd = q[0].bcd;
                    void'(q.pop_front());
                end
                check("bcd", bcd, m_bcd);
            end
            if (rst) begin
                q.delete();
                m_cnt = 0;
                m_bcd = '0;
            end else if (m_cnt == 0 && load) begin
                q.push_back('{to_bcd(int'(value_in)), cyc});
                m_cnt = 7;
            end else if (m_cnt > 0) begin
                m_cnt--;
            end
        end
    end

    task automatic drive(input logic l, input int v, input logic r);
        load     = l;
        value_in = 7'(v);
        rst      = r;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 0, 1'b0);
    endtask

    task automatic disp_check(input int v);
        logic [2:0] prev;
        bit         found;
        int         h, t, u, slot;
        logic [6:0] es;
        h = v / 100;
        t = (v / 10) % 10;
        u = v % 10;
        found = 0;
        @(negedge clk);
        prev = an;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            if (an == 3'b110 && prev != 3'b110) begin
                found = 1;
                break;
            end
            prev = an;
        end
        check("disp_sync", found, 1);
        if (found) begin
            for (int i = 0; i < 12; i++) begin
                if (i > 0) @(negedge clk);
                slot = i / 4;
                case (slot)
                    0: es = seg_of(u);
                    1: es = (h == 0 && t == 0) ? 7'b1111111 : seg_of(t);
                    default: es = (h == 0) ? 7'b1111111 : seg_of(h);
                endcase
                check("an", an, ~(3'b001 << slot) & 3'b111);
                check("seg", seg, es);
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; load = 1'b0; value_in = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_an", an, 3'b110);
        check("rst_seg", seg, 7'b1000000);
        check("rst_busy", busy, 0);
        check("rst_valid", bcd_valid, 0);
        check("rst_bcd", bcd, 12'h000);
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk_en = 1;
        idle(2);

        drive(1'b1, 127, 1'b0);
        idle(10);
        disp_check(127);
        drive(1'b1, 0, 1'b0);
        idle(10);
        disp_check(0);
        drive(1'b1, 9, 1'b0);
        idle(10);
        disp_check(9);
        drive(1'b1, 105, 1'b0);
        idle(10);
        disp_check(105);

        // Second load while busy is dropped; load in cycle N+8 is taken.
        drive(1'b1, 127, 1'b0);
        drive(1'b1, 64, 1'b0);
        idle(6);
        drive(1'b1, 64, 1'b0);
        idle(10);

        // Reset in the middle of a conversion of 99.
        drive(1'b1, 127, 1'b0);
        idle(10);
        drive(1'b1, 99, 1'b0);
        idle(3);
        drive(1'b0, 0, 1'b1);
        load = 1'b0; rst = 1'b0;
        @(negedge clk);
        check("abort_an", an, 3'b110);
        @(posedge clk);
        #1;
        idle(2);
        drive(1'b1, 99, 1'b0);
        idle(10);
        disp_check(99);

        for (int v = 0; v < 128; v++) begin
            drive(1'b1, v, 1'b0);
            idle(7);
        end
        idle(10);
        check("queue_empty", q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/count_bcd_display.md
Name: count_bcd_display

Overview:
- Downstream consumer of the 7-bit seconds counter.
- Takes a 7-bit binary value (0..127) on a load strobe and converts it to 3-digit BCD with a sequential shift-add-3 (double-dabble) engine.
- Drives a 3-digit multiplexed common-anode 7-segment display from the last completed result, with leading-zero blanking.
- Sits between the counter and the board display pins, in the fast system clock domain.

Parameters:
- REFRESH_DIV, 100000, clk cycles each digit is enabled before advancing to the next digit; legal range >= 2.

Ports:
- clk  in  1  system clock, rising-edge.
- rst  in  1  synchronous, active-high reset.
- value_in  in  7  binary value to convert, sampled only when load is accepted.
- load  in  1  one-cycle request strobe.
- busy  out  1  high while a conversion is in progress.
- bcd_valid  out  1  one-cycle pulse when bcd is updated.
- bcd  out  12  [11:8] hundreds, [7:4] tens, [3:0] units.
- seg  out  7  active-low segments, seg[0]=a .. seg[6]=g.
- an  out  3  active-low digit enables: an[0] units, an[1] tens, an[2] hundreds.

Behaviour:
- Reset values (rst sampled high at a clk edge):
  - State IDLE; busy=0, bcd_valid=0, bcd=12'h000.
  - Refresh counter = 0; digit select = 0 (units), so an=3'b110 and seg=7'b1000000 ('0').
- Reset has priority over all other activity, including a conversion in progress. A conversion aborted by reset produces no bcd_valid, and bcd returns to 0.
- FSM states: IDLE, CONV.
- IDLE:
  - If load=1, capture value_in into the shift register, clear the BCD scratch and the iteration count to 0, and go to CONV.
  - Otherwise remain in IDLE.
- CONV:
  - Each cycle, in order: add 3 to each scratch nibble that is >= 5; then shift {scratch, shift register} left by 1; then increment the iteration count.
  - After the 7th iteration: write scratch to bcd, pulse bcd_valid, return to IDLE.
  - load is ignored while in CONV (dropped, not queued).
- Timing (load accepted in cycle N):
  - busy=1 in cycles N+1..N+7.
  - New bcd value and bcd_valid=1 are visible in cycle N+8; busy=0 in N+8.
  - A load in cycle N+8 is accepted.
- bcd holds its value between conversions; bcd_valid is high exactly one cycle per completed conversion.
- Arithmetic:
  - Scratch is 12 bits; all additions are per-nibble 4-bit.
  - The maximum input of 127 gives 0x127; no nibble ever exceeds 9 in the final result.
- Refresh:
  - The refresh counter counts 0..REFRESH_DIV-1 and wraps.
  - On the wrap cycle, digit select advances 0 -> 1 -> 2 -> 0.
  - Each digit is enabled for exactly REFRESH_DIV cycles.
  - Refresh runs continuously and is independent of the conversion FSM.
- an, seg:
  - Derived from registered digit select and the registered bcd only, never from scratch. The display therefore does not change during CONV.
  - an drives exactly one bit low at all times after reset.
- Segment encoding (active-low, g..a), digits 0-9:
  - 0 = 1000000, 1 = 1111001, 2 = 0100100, 3 = 0110000, 4 = 0011001
  - 5 = 0010010, 6 = 0000010, 7 = 1111000, 8 = 0000000, 9 = 0010000
- Leading-zero blanking:
  - Hundreds digit is blanked when it is 0.
  - Tens digit is blanked when hundreds=0 and tens=0.
  - Units digit is never blanked.
  - A blanked digit still has its an bit driven low during its slot, with seg=7'b1111111.

Test Plan:
- Reset, then load value_in=127 -> busy high for exactly 7 cycles; bcd=12'h127 and bcd_valid=1 in cycle N+8; bcd_valid=0 in N+9.
- REFRESH_DIV=4, bcd=0x127 -> an cycles 110, 101, 011 with 4 cycles per slot; seg shows 1111000 (7), then 0100100 (2), then 1111001 (1).
- load 0 -> bcd=0x000; units slot seg=1000000; tens and hundreds slots seg=1111111. load 9 -> tens and hundreds slots blank, units seg=0010000. load 105 -> tens slot shows 1000000 (not blanked).
- Loads of 127 then 64 back-to-back -> second load (issued while busy=1) is ignored, bcd stays 0x127, only one bcd_valid pulse. load 64 issued in cycle N+8 -> accepted, bcd=0x064.
- Reset asserted in cycle N+4 of a conversion of 99 (previous bcd=0x127) -> next cycle busy=0, bcd=0x000, an=110, no bcd_valid. A subsequent load of 99 yields 0x099.
- Sweep all 128 inputs -> bcd matches the decimal reference for each; each conversion takes exactly 8 cycles from load to bcd_valid.
